// File: rtl/control_unit_md_if.sv
// ID-stage control bundle between the IF/ID register, EX and the multiply/divide unit.
// master drives instruction fields and hazard inputs; slave is the control unit.
interface control_unit_md_if #(
  parameter int unsigned ALU_CTRL_W = 4
);
  logic [6:0]            Opcode;
  logic [2:0]            Funct3;
  logic [6:0]            Funct7;
  logic                  NOP_Ins;
  logic                  CTRL_FLUSH;
  logic                  Hold;

  logic                  EN_PC;
  logic                  MD_Start;
  logic [2:0]            MD_Op;
  logic                  MD_Abort;
  logic                  MD_Busy;

  logic                  MEM_Wr_En;
  logic                  Reg_Wr_En;
  logic                  ALU_Src1_Sel;
  logic                  ALU_Src2_Sel;
  logic                  Sub;
  logic                  Branch;
  logic                  Jump;
  logic                  MD_Sel;
  logic                  undef_instr;
  logic [1:0]            Src_to_Reg;
  logic [ALU_CTRL_W-1:0] ALU_Ctrl;

  modport master (
    output Opcode, Funct3, Funct7, NOP_Ins, CTRL_FLUSH, Hold,
    input  EN_PC, MD_Start, MD_Op, MD_Abort, MD_Busy,
    input  MEM_Wr_En, Reg_Wr_En, ALU_Src1_Sel, ALU_Src2_Sel, Sub, Branch, Jump,
    input  MD_Sel, undef_instr, Src_to_Reg, ALU_Ctrl
  );

  modport slave (
    input  Opcode, Funct3, Funct7, NOP_Ins, CTRL_FLUSH, Hold,
    output EN_PC, MD_Start, MD_Op, MD_Abort, MD_Busy,
    output MEM_Wr_En, Reg_Wr_En, ALU_Src1_Sel, ALU_Src2_Sel, Sub, Branch, Jump,
    output MD_Sel, undef_instr, Src_to_Reg, ALU_Ctrl
  );
endinterface

// File: rtl/control_unit_md.sv
// RV32IM ID-stage control unit: decodes into the ID/EX register and sequences
// multi-cycle multiply/divide operations by stalling fetch until the result is ready.
module control_unit_md #(
  parameter int unsigned ALU_CTRL_W = 4,
  parameter int unsigned MUL_LAT    = 2,
  parameter int unsigned DIV_LAT    = 33,
  parameter int unsigned EN_M       = 1
) (
  input logic              CLK,
  input logic              rst_n,
  control_unit_md_if.slave bus
);

  localparam int unsigned CNT_W = $clog2(DIV_LAT + 1);

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;
  localparam logic [6:0] F7_MD   = 7'b0000001;

  typedef struct packed {
    logic       mem_wr_en;
    logic       reg_wr_en;
    logic       src1_sel;
    logic       src2_sel;
    logic       sub;
    logic       branch;
    logic       jump;
    logic       md_sel;
    logic       undef;
    logic [1:0] src_to_reg;
    logic [3:0] alu_ctrl;
  } ctrl_t;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  ctrl_t             ctrl_q, ctrl_d;
  ctrl_t             dec;
  logic              abort_q, abort_d;
  logic              busy_q;
  logic              is_md;
  logic              is_div;
  logic              kill;
  logic              en_pc;
  logic              md_start;

  // Pure instruction decode; MD ops produce no controls here, only is_md/is_div.
  always_comb begin
    dec    = '0;
    is_md  = 1'b0;
    is_div = 1'b0;
    case (bus.Opcode)
      OPC_OP: begin
        if ((bus.Funct7 == F7_MD) && (EN_M != 0)) begin
          is_md  = 1'b1;
          is_div = bus.Funct3[2];
        end else if ((bus.Funct7 == F7_BASE) ||
                     ((bus.Funct7 == F7_ALT) &&
                      ((bus.Funct3 == 3'b000) || (bus.Funct3 == 3'b101)))) begin
          dec.reg_wr_en = 1'b1;
          dec.alu_ctrl  = {bus.Funct7[5], bus.Funct3};
          dec.sub       = bus.Funct7[5] & (bus.Funct3 == 3'b000);
        end else begin
          dec.undef = 1'b1;
        end
      end
      OPC_OP_IMM: begin
        if (((bus.Funct3 == 3'b001) && (bus.Funct7 != F7_BASE)) ||
            ((bus.Funct3 == 3'b101) && (bus.Funct7 != F7_BASE) && (bus.Funct7 != F7_ALT))) begin
          dec.undef = 1'b1;
        end else begin
          dec.reg_wr_en = 1'b1;
          dec.src2_sel  = 1'b1;
          dec.alu_ctrl  = {(bus.Funct3 == 3'b101) & bus.Funct7[5], bus.Funct3};
        end
      end
      OPC_LOAD: begin
        dec.reg_wr_en  = 1'b1;
        dec.src2_sel   = 1'b1;
        dec.src_to_reg = 2'b01;
      end
      OPC_STORE: begin
        dec.mem_wr_en = 1'b1;
        dec.src2_sel  = 1'b1;
      end
      OPC_BRANCH: begin
        dec.branch = 1'b1;
        dec.sub    = 1'b1;
      end
      OPC_JAL: begin
        dec.jump       = 1'b1;
        dec.reg_wr_en  = 1'b1;
        dec.src_to_reg = 2'b10;
        dec.src1_sel   = 1'b1;
        dec.src2_sel   = 1'b1;
      end
      OPC_JALR: begin
        dec.jump       = 1'b1;
        dec.reg_wr_en  = 1'b1;
        dec.src_to_reg = 2'b10;
        dec.src2_sel   = 1'b1;
      end
      OPC_LUI: begin
        dec.reg_wr_en  = 1'b1;
        dec.src_to_reg = 2'b11;
      end
      OPC_AUIPC: begin
        dec.reg_wr_en = 1'b1;
        dec.src1_sel  = 1'b1;
        dec.src2_sel  = 1'b1;
      end
      default: dec.undef = 1'b1;
    endcase
  end

  assign kill = bus.NOP_Ins | bus.CTRL_FLUSH | bus.Hold;

  // MD sequencer next state plus ID/EX next value; bubble unless explicitly loaded.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    ctrl_d   = '0;
    abort_d  = 1'b0;
    en_pc    = ~bus.Hold;
    md_start = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (is_md && !kill) begin
          md_start = 1'b1;
          en_pc    = 1'b0;
          cnt_d    = is_div ? CNT_W'(DIV_LAT - 1) : CNT_W'(MUL_LAT - 1);
          state_d  = S_BUSY;
        end else if (!kill) begin
          ctrl_d = dec;
        end
      end
      S_BUSY: begin
        if (bus.CTRL_FLUSH) begin
          en_pc   = 1'b1;
          abort_d = 1'b1;
          cnt_d   = '0;
          state_d = S_IDLE;
        end else begin
          en_pc = 1'b0;
          if (cnt_q == CNT_W'(1)) begin
            cnt_d   = '0;
            state_d = S_DONE;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
      end
      S_DONE: begin
        if (bus.CTRL_FLUSH) begin
          en_pc   = 1'b1;
          abort_d = 1'b1;
          state_d = S_IDLE;
        end else if (!bus.Hold) begin
          ctrl_d.reg_wr_en = 1'b1;
          ctrl_d.md_sel    = 1'b1;
          state_d          = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      ctrl_q  <= '0;
      abort_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ctrl_q  <= ctrl_d;
      abort_q <= abort_d;
      busy_q  <= (state_d != S_IDLE);
    end
  end

  // Combinational handshakes are forced to their idle values while reset is held.
  assign bus.EN_PC    = en_pc | ~rst_n;
  assign bus.MD_Start = md_start & rst_n;
  assign bus.MD_Op    = (md_start & rst_n) ? bus.Funct3 : 3'b000;
  assign bus.MD_Abort = abort_q;
  assign bus.MD_Busy  = busy_q;

  assign bus.MEM_Wr_En    = ctrl_q.mem_wr_en;
  assign bus.Reg_Wr_En    = ctrl_q.reg_wr_en;
  assign bus.ALU_Src1_Sel = ctrl_q.src1_sel;
  assign bus.ALU_Src2_Sel = ctrl_q.src2_sel;
  assign bus.Sub          = ctrl_q.sub;
  assign bus.Branch       = ctrl_q.branch;
  assign bus.Jump         = ctrl_q.jump;
  assign bus.MD_Sel       = ctrl_q.md_sel;
  assign bus.undef_instr  = ctrl_q.undef;
  assign bus.Src_to_Reg   = ctrl_q.src_to_reg;
  assign bus.ALU_Ctrl     = ALU_CTRL_W'(ctrl_q.alu_ctrl);

endmodule

// File: tb/tb_control_unit_md.sv
// Bench for control_unit_md: decode table, MD sequencing corner cases and a
// randomized stream checked against an elapsed-cycle reference model.
module tb_control_unit_md;

  localparam int unsigned MUL_LAT = 2;
  localparam int unsigned DIV_LAT = 33;

  logic CLK = 1'b0;
  logic rst_n;
  always #5 CLK = ~CLK;

  control_unit_md_if #(.ALU_CTRL_W(4)) bus ();
  control_unit_md_if #(.ALU_CTRL_W(4)) bus2 ();

  assign bus2.Opcode     = bus.Opcode;
  assign bus2.Funct3     = bus.Funct3;
  assign bus2.Funct7     = bus.Funct7;
  assign bus2.NOP_Ins    = bus.NOP_Ins;
  assign bus2.CTRL_FLUSH = bus.CTRL_FLUSH;
  assign bus2.Hold       = bus.Hold;

  control_unit_md #(.ALU_CTRL_W(4), .MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT), .EN_M(1))
    dut (.CLK(CLK), .rst_n(rst_n), .bus(bus));
  control_unit_md #(.ALU_CTRL_W(4), .MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT), .EN_M(0))
    dut_nm (.CLK(CLK), .rst_n(rst_n), .bus(bus2));

  typedef struct packed {
    logic       mem_wr;
    logic       reg_wr;
    logic       src1;
    logic       src2;
    logic       sub;
    logic       branch;
    logic       jump;
    logic       md_sel;
    logic       undef;
    logic [1:0] s2r;
    logic [3:0] alu;
  } ctl_t;

  typedef struct {
    string      name;
    logic [6:0] op;
    logic [2:0] f3;
    logic [6:0] f7;
    ctl_t       exp;
  } vec_t;

  vec_t vecs[$];
  int   checks = 0;
  int   errors = 0;

  // reference model state: MD op tracked as start cycle + latency
  int   cyc = 0;
  bit   m_active, n_active;
  int   m_start, n_start, m_lat, n_lat;
  ctl_t m_q, n_q;
  bit   m_abort_q, n_abort, m_busy_q;
  bit   exp_en_pc, exp_start;

  bit   s_en_pc = 1'b1, s_start, s_busy, s_abort, s_wr;
  bit   s2_start, s2_en, s2_undef;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic ctl_t mk(bit mem, bit rw, bit s1, bit s2, bit sub, bit br, bit jmp,
                              bit und, logic [1:0] s2r, logic [3:0] alu);
    ctl_t c;
    c = '{mem_wr: mem, reg_wr: rw, src1: s1, src2: s2, sub: sub, branch: br, jump: jmp,
          md_sel: 1'b0, undef: und, s2r: s2r, alu: alu};
    return c;
  endfunction

  function automatic ctl_t dut_ctl();
    ctl_t c;
    c = '{mem_wr: bus.MEM_Wr_En, reg_wr: bus.Reg_Wr_En, src1: bus.ALU_Src1_Sel,
          src2: bus.ALU_Src2_Sel, sub: bus.Sub, branch: bus.Branch, jump: bus.Jump,
          md_sel: bus.MD_Sel, undef: bus.undef_instr, s2r: bus.Src_to_Reg, alu: bus.ALU_Ctrl};
    return c;
  endfunction

  // Decode rules straight from the instruction-set table.
  task automatic ref_decode(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                            output ctl_t c, output bit md, output bit div);
    c = '0; md = 1'b0; div = 1'b0;
    if (op == 7'h33) begin
      if (f7 == 7'h01) begin md = 1'b1; div = f3[2]; end
      else if (f7 == 7'h00 || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5))) begin
        c.reg_wr = 1'b1; c.alu = {f7[5], f3}; c.sub = (f7 == 7'h20) && (f3 == 3'd0);
      end else c.undef = 1'b1;
    end else if (op == 7'h13) begin
      if ((f3 == 3'd1 && f7 != 7'h00) || (f3 == 3'd5 && f7 != 7'h00 && f7 != 7'h20))
        c.undef = 1'b1;
      else begin
        c.reg_wr = 1'b1; c.src2 = 1'b1; c.alu = {(f3 == 3'd5) && f7[5], f3};
      end
    end
    else if (op == 7'h03) c = mk(0, 1, 0, 1, 0, 0, 0, 0, 2'b01, 4'h0);
    else if (op == 7'h23) c = mk(1, 0, 0, 1, 0, 0, 0, 0, 2'b00, 4'h0);
    else if (op == 7'h63) c = mk(0, 0, 0, 0, 1, 1, 0, 0, 2'b00, 4'h0);
    else if (op == 7'h6F) c = mk(0, 1, 1, 1, 0, 0, 1, 0, 2'b10, 4'h0);
    else if (op == 7'h67) c = mk(0, 1, 0, 1, 0, 0, 1, 0, 2'b10, 4'h0);
    else if (op == 7'h37) c = mk(0, 1, 0, 0, 0, 0, 0, 0, 2'b11, 4'h0);
    else if (op == 7'h17) c = mk(0, 1, 1, 1, 0, 0, 0, 0, 2'b00, 4'h0);
    else c.undef = 1'b1;
  endtask

  task automatic model_reset();
    m_active = 1'b0; m_start = 0; m_lat = 0; m_q = '0; m_abort_q = 1'b0; m_busy_q = 1'b0;
  endtask

  task automatic model_eval();
    ctl_t d;
    bit   md, div, kill;
    int   el;
    n_q = '0; n_abort = 1'b0; n_active = m_active; n_start = m_start; n_lat = m_lat;
    exp_start = 1'b0;
    kill = bus.NOP_Ins | bus.CTRL_FLUSH | bus.Hold;
    if (!m_active) begin
      ref_decode(bus.Opcode, bus.Funct3, bus.Funct7, d, md, div);
      if (md && !kill) begin
        exp_start = 1'b1; exp_en_pc = 1'b0;
        n_active = 1'b1; n_start = cyc; n_lat = div ? int'(DIV_LAT) : int'(MUL_LAT);
      end else begin
        exp_en_pc = !bus.Hold;
        if (!kill) n_q = d;
      end
    end else begin
      el = cyc - m_start;
      if (bus.CTRL_FLUSH) begin
        exp_en_pc = 1'b1; n_abort = 1'b1; n_active = 1'b0;
      end else if (el < m_lat) begin
        exp_en_pc = 1'b0;
      end else begin
        exp_en_pc = !bus.Hold;
        if (!bus.Hold) begin n_q.reg_wr = 1'b1; n_q.md_sel = 1'b1; n_active = 1'b0; end
      end
    end
  endtask

  task automatic model_commit();
    m_q = n_q; m_abort_q = n_abort; m_active = n_active; m_start = n_start; m_lat = n_lat;
    m_busy_q = n_active;
    cyc++;
  endtask

  task automatic drive(logic [6:0] op, logic [2:0] f3, logic [6:0] f7,
                       logic nop, logic fl, logic hd);
    bus.Opcode = op; bus.Funct3 = f3; bus.Funct7 = f7;
    bus.NOP_Ins = nop; bus.CTRL_FLUSH = fl; bus.Hold = hd;
  endtask

  // One clock: entered and left 1 time unit after the rising edge; checks mid-cycle.
  task automatic step();
    ctl_t got;
    #4;
    model_eval();
    s_en_pc = bus.EN_PC; s_start = bus.MD_Start; s_busy = bus.MD_Busy; s_abort = bus.MD_Abort;
    got = dut_ctl(); s_wr = got.reg_wr & got.md_sel;
    s2_start = bus2.MD_Start; s2_en = bus2.EN_PC; s2_undef = bus2.undef_instr;
    chk("EN_PC", 32'(s_en_pc), 32'(exp_en_pc));
    chk("MD_Start", 32'(s_start), 32'(exp_start));
    if (exp_start) chk("MD_Op", 32'(bus.MD_Op), 32'(bus.Funct3));
    chk("MD_Abort", 32'(s_abort), 32'(m_abort_q));
    chk("MD_Busy", 32'(s_busy), 32'(m_busy_q));
    chk("ID/EX", 32'(got), 32'(m_q));
    @(posedge CLK);
    #1;
    model_commit();
  endtask

  task automatic nops(int n);
    for (int i = 0; i < n; i++) begin
      drive(7'h00, 3'd0, 7'h00, 1'b1, 1'b0, 1'b0);
      step();
    end
  endtask

  task automatic addv(string n, logic [6:0] op, logic [2:0] f3, logic [6:0] f7, ctl_t e);
    vec_t v;
    v.name = n; v.op = op; v.f3 = f3; v.f7 = f7; v.exp = e;
    vecs.push_back(v);
  endtask

  initial begin
    int lowcnt, busycnt, wbc, wrcnt;
    int r;
    logic [6:0] op, f7;
    logic [2:0] f3;

    addv("ADD",     7'h33, 3'd0, 7'h00, mk(0, 1, 0, 0, 0, 0, 0, 0, 2'b00, 4'h0));
    addv("SUB",     7'h33, 3'd0, 7'h20, mk(0, 1, 0, 0, 1, 0, 0, 0, 2'b00, 4'h8));
    addv("SRA",     7'h33, 3'd5, 7'h20, mk(0, 1, 0, 0, 0, 0, 0, 0, 2'b00, 4'hD));
    addv("SLT",     7'h33, 3'd2, 7'h00, mk(0, 1, 0, 0, 0, 0, 0, 0, 2'b00, 4'h2));
    addv("OP_BADALT", 7'h33, 3'd1, 7'h20, mk(0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 4'h0));
    addv("OP_BADF7", 7'h33, 3'd0, 7'h10, mk(0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 4'h0));
    addv("SRAI",    7'h13, 3'd5, 7'h20, mk(0, 1, 0, 1, 0, 0, 0, 0, 2'b00, 4'hD));
    addv("ADDI_F7", 7'h13, 3'd0, 7'h20, mk(0, 1, 0, 1, 0, 0, 0, 0, 2'b00, 4'h0));
    addv("SLLI_BAD", 7'h13, 3'd1, 7'h01, mk(0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 4'h0));
    addv("SRLI_BAD", 7'h13, 3'd5, 7'h01, mk(0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 4'h0));
    addv("LW",      7'h03, 3'd2, 7'h00, mk(0, 1, 0, 1, 0, 0, 0, 0, 2'b01, 4'h0));
    addv("SW",      7'h23, 3'd2, 7'h00, mk(1, 0, 0, 1, 0, 0, 0, 0, 2'b00, 4'h0));
    addv("BEQ",     7'h63, 3'd0, 7'h00, mk(0, 0, 0, 0, 1, 1, 0, 0, 2'b00, 4'h0));
    addv("JAL",     7'h6F, 3'd0, 7'h00, mk(0, 1, 1, 1, 0, 0, 1, 0, 2'b10, 4'h0));
    addv("JALR",    7'h67, 3'd0, 7'h00, mk(0, 1, 0, 1, 0, 0, 1, 0, 2'b10, 4'h0));
    addv("LUI",     7'h37, 3'd0, 7'h00, mk(0, 1, 0, 0, 0, 0, 0, 0, 2'b11, 4'h0));
    addv("AUIPC",   7'h17, 3'd0, 7'h00, mk(0, 1, 1, 1, 0, 0, 0, 0, 2'b00, 4'h0));
    addv("UNDEF7F", 7'h7F, 3'd0, 7'h00, mk(0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 4'h0));

    // reset values
    rst_n = 1'b0;
    drive(7'h33, 3'd4, 7'h01, 1'b0, 1'b0, 1'b0);
    #1;
    chk("rst_EN_PC", 32'(bus.EN_PC), 32'd1);
    chk("rst_MD_Start", 32'(bus.MD_Start), 32'd0);
    chk("rst_MD_Busy", 32'(bus.MD_Busy), 32'd0);
    chk("rst_MD_Abort", 32'(bus.MD_Abort), 32'd0);
    chk("rst_ID/EX", 32'(dut_ctl()), 32'd0);
    model_reset();
    drive(7'h00, 3'd0, 7'h00, 1'b1, 1'b0, 1'b0);
    #10 rst_n = 1'b1;
    @(posedge CLK);
    #1;

    // decode table: controls visible one cycle after ID
    foreach (vecs[i]) begin
      drive(vecs[i].op, vecs[i].f3, vecs[i].f7, 1'b0, 1'b0, 1'b0);
      step();
      chk(vecs[i].name, 32'(dut_ctl()), 32'(vecs[i].exp));
    end
    nops(2);

    // MUL at cycle 0
    for (int c = 0; c < 6; c++) begin
      if (c <= int'(MUL_LAT)) drive(7'h33, 3'd0, 7'h01, 1'b0, 1'b0, 1'b0);
      else drive(7'h00, 3'd0, 7'h00, 1'b1, 1'b0, 1'b0);
      step();
      chk("mul_start", 32'(s_start), 32'(c == 0));
      chk("mul_en_pc", 32'(s_en_pc), 32'(c >= int'(MUL_LAT)));
      chk("mul_wb", 32'(s_wr), 32'(c == int'(MUL_LAT) + 1));
    end

    // DIV at cycle 0
    lowcnt = 0; busycnt = 0; wbc = -1;
    for (int c = 0; c < 38; c++) begin
      if (c <= int'(DIV_LAT)) drive(7'h33, 3'd4, 7'h01, 1'b0, 1'b0, 1'b0);
      else drive(7'h00, 3'd0, 7'h00, 1'b1, 1'b0, 1'b0);
      step();
      if (!s_en_pc) lowcnt++;
      if (s_busy) busycnt++;
      if (s_wr) wbc = c;
    end
    chk("div_en_pc_low", 32'(lowcnt), 32'd33);
    chk("div_busy_cycles", 32'(busycnt), 32'd33);
    chk("div_wb_cycle", 32'(wbc), 32'd34);

    // CTRL_FLUSH in BUSY cycle 5 of a DIV
    wrcnt = 0;
    for (int c = 0; c < 41; c++) begin
      if (c < 5) drive(7'h33, 3'd5, 7'h01, 1'b0, 1'b0, 1'b0);
      else if (c == 5) drive(7'h33, 3'd5, 7'h01, 1'b0, 1'b1, 1'b0);
      else drive(7'h00, 3'd0, 7'h00, 1'b1, 1'b0, 1'b0);
      step();
      if (c == 5) chk("flush_en_pc", 32'(s_en_pc), 32'd1);
      if (c == 6) chk("flush_abort", 32'(s_abort), 32'd1);
      if (c == 6) chk("flush_busy", 32'(s_busy), 32'd0);
      if (c == 7) chk("flush_abort_pulse", 32'(s_abort), 32'd0);
      if (s_wr) wrcnt++;
    end
    chk("flush_no_wb", 32'(wrcnt), 32'd0);

    // Hold in DONE for 3 cycles
    for (int c = 0; c < 9; c++) begin
      if (c <= 5) drive(7'h33, 3'd1, 7'h01, 1'b0, 1'b0, 1'((c >= 2) && (c <= 4)));
      else drive(7'h00, 3'd0, 7'h00, 1'b1, 1'b0, 1'b0);
      step();
      chk("hold_en_pc", 32'(s_en_pc), 32'(c >= 5));
      chk("hold_wb", 32'(s_wr), 32'(c == 6));
    end

    // EN_M=0 instance sees MUL as undefined
    for (int c = 0; c < 6; c++) begin
      if (c <= int'(MUL_LAT)) drive(7'h33, 3'd0, 7'h01, 1'b0, 1'b0, 1'b0);
      else drive(7'h00, 3'd0, 7'h00, 1'b1, 1'b0, 1'b0);
      step();
      chk("nm_start", 32'(s2_start), 32'd0);
      if (c == 0) chk("nm_en_pc", 32'(s2_en), 32'd1);
      if (c == 1) chk("nm_undef", 32'(s2_undef), 32'd1);
    end

    // asynchronous reset while BUSY
    for (int c = 0; c < 4; c++) begin
      drive(7'h33, 3'd4, 7'h01, 1'b0, 1'b0, 1'b0);
      step();
    end
    #2 rst_n = 1'b0;
    #1;
    chk("rstb_EN_PC", 32'(bus.EN_PC), 32'd1);
    chk("rstb_MD_Start", 32'(bus.MD_Start), 32'd0);
    chk("rstb_MD_Busy", 32'(bus.MD_Busy), 32'd0);
    chk("rstb_MD_Abort", 32'(bus.MD_Abort), 32'd0);
    chk("rstb_ID/EX", 32'(dut_ctl()), 32'd0);
    model_reset();
    drive(7'h00, 3'd0, 7'h00, 1'b1, 1'b0, 1'b0);
    @(posedge CLK);
    #1 rst_n = 1'b1;
    nops(3);

    // randomized stream; ID holds its instruction while fetch is stalled
    op = 7'h00; f3 = 3'd0; f7 = 7'h00;
    for (int i = 0; i < 3000; i++) begin
      if (s_en_pc) begin
        r = int'($urandom_range(11, 0));
        case (r)
          0, 1, 2, 3: op = 7'h33;
          4: op = 7'h13;
          5: op = 7'h03;
          6: op = 7'h23;
          7: op = 7'h63;
          8: op = 7'h6F;
          9: op = 7'h67;
          10: op = ($urandom_range(1, 0) != 0) ? 7'h37 : 7'h17;
          default: op = 7'($urandom());
        endcase
        f3 = 3'($urandom());
        r = int'($urandom_range(3, 0));
        f7 = (r == 0) ? 7'h00 : (r == 1) ? 7'h20 : (r == 2) ? 7'h01 : 7'($urandom());
      end
      drive(op, f3, f7, 1'($urandom_range(9, 0) == 0), 1'($urandom_range(39, 0) == 0),
            1'($urandom_range(5, 0) == 0));
      step();
    end
    for (int i = 0; i < 80 && m_active; i++) nops(1);
    chk("final_idle", 32'(m_active), 32'd0);
    nops(2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/control_unit_md.md
# control_unit_md

Pipelined RV32IM control unit: decodes the instruction in ID, registers all control signals into the ID/EX stage, and sequences multi-cycle M-extension (MUL/DIV/REM) operations with a stall FSM. It sits between the IF/ID register and EX, drives the PC-enable to the fetch stage, and handshakes with the external multiply/divide unit. All decode outputs are ID/EX-registered.

## Interface
Parameters:
- ALU_CTRL_W, 4, ALU_Ctrl width (4..8); bits above [3] are always 0
- MUL_LAT, 2, cycles a MUL-class op occupies the MD unit (2..8)
- DIV_LAT, 33, cycles a DIV/REM-class op occupies the MD unit (2..64)
- EN_M, 1, 1 = M-extension decoded; 0 = funct7 0000001 on OP is undefined

Ports:
- CLK  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- Opcode  in  7  instruction[6:0]
- Funct3  in  3  instruction[14:12]
- Funct7  in  7  instruction[31:25]
- NOP_Ins  in  1  ID holds a bubble
- CTRL_FLUSH  in  1  squash ID (taken branch/jump)
- Hold  in  1  hazard-unit stall (load-use)
- EN_PC  out  1  PC and IF/ID enable (combinational)
- MD_Start  out  1  one-cycle start pulse to MD unit (combinational)
- MD_Op  out  3  Funct3 of the MD op, valid with MD_Start
- MD_Abort  out  1  one-cycle registered pulse: MD op cancelled
- MD_Busy  out  1  FSM not IDLE
- MEM_Wr_En, Reg_Wr_En, ALU_Src1_Sel, ALU_Src2_Sel, Sub, Branch, Jump, MD_Sel, undef_instr  out  1 each  ID/EX registered
- Src_to_Reg  out  2  ID/EX registered: 00 ALU/MD, 01 memory, 10 PC+4, 11 immediate
- ALU_Ctrl  out  ALU_CTRL_W  ID/EX registered

## Operation
- Decode (Src1: 0 rs1 / 1 PC; Src2: 0 rs2 / 1 imm; unlisted signals 0):
  - OP 0110011, Funct7 0000000/0100000: Reg_Wr_En; ALU_Ctrl[2:0]=Funct3, [3]=Funct7[5]; Sub=Funct7[5]&(Funct3==000). Funct7[5]=1 with Funct3 not 000/101 → undefined.
  - OP, Funct7 0000001, EN_M=1: MD op; MUL class Funct3[2]=0 (MUL_LAT), DIV class Funct3[2]=1 (DIV_LAT).
  - OP-IMM 0010011: Reg_Wr_En, Src2=1, ALU_Ctrl[2:0]=Funct3, [3]=Funct7[5] only if Funct3=101; Funct3=001 with Funct7≠0, or 101 with Funct7∉{0000000,0100000} → undefined.
  - LOAD 0000011: Reg_Wr_En, Src2=1, Src_to_Reg=01. STORE 0100011: MEM_Wr_En, Src2=1.
  - BRANCH 1100011: Branch, Sub. JAL 1101111: Jump, Reg_Wr_En, Src_to_Reg=10, Src1=1, Src2=1. JALR 1100111: Jump, Reg_Wr_En, Src_to_Reg=10, Src2=1.
  - LUI 0110111: Reg_Wr_En, Src_to_Reg=11. AUIPC 0010111: Reg_Wr_En, Src1=1, Src2=1.
  - Anything else: undef_instr=1, all enables 0.
- Bubble = all ID/EX outputs 0. Loaded when NOP_Ins, CTRL_FLUSH, Hold, or FSM in IDLE(MD start)/BUSY.
- FSM IDLE/BUSY/DONE, counter cnt width clog2(DIV_LAT+1):
  - IDLE: MD decoded & !NOP_Ins & !CTRL_FLUSH & !Hold → MD_Start=1, MD_Op=Funct3, EN_PC=0, cnt←LAT-1, →BUSY.
  - BUSY: EN_PC=0; cnt==1 → DONE, else cnt−1. Hold does not freeze cnt.
  - DONE: EN_PC=!Hold; if !Hold load ID/EX with Reg_Wr_En=1, MD_Sel=1, Src_to_Reg=00, →IDLE; if Hold stay DONE with bubble.
  - CTRL_FLUSH in BUSY/DONE: →IDLE, MD_Abort=1 next cycle, bubble, EN_PC=1.
- EN_PC outside MD sequence = !Hold.

## Timing
- Reset: state IDLE, cnt 0, all ID/EX outputs and MD_Abort 0; EN_PC=1, MD_Start=0, MD_Busy=0.
- Non-MD instruction: controls visible on ID/EX outputs 1 cycle after ID.
- MD op starting cycle 0: EN_PC low cycles 0..LAT-1, DONE in cycle LAT, Reg_Wr_En/MD_Sel high in cycle LAT+1 for one cycle; next instruction enters ID at cycle LAT+1.
- MD_Start never asserted while MD_Busy=1; back-to-back MD ops restart from IDLE.
- rst_n low mid-sequence: immediate IDLE, outputs to reset values.

## Test plan
- Each RV32I opcode (ADD, SUB, SRAI, LW, SW, BEQ, JAL, JALR, LUI, AUIPC) → exact field values above one cycle later; opcode 1111111 → undef_instr=1, enables 0.
- MUL with MUL_LAT=2 at cycle 0 → MD_Start cycle 0, EN_PC=0 cycles 0–1, Reg_Wr_En=MD_Sel=1 in cycle 3 only.
- DIV with DIV_LAT=33 → EN_PC low 33 cycles, MD_Busy high 33 cycles, writeback cycle 34.
- CTRL_FLUSH in BUSY cycle 5 of DIV → MD_Abort pulse cycle 6, IDLE, no Reg_Wr_En, EN_PC=1 cycle 5.
- Hold=1 in DONE for 3 cycles → bubbles, EN_PC=0, writeback issued cycle after Hold drops; EN_M=0 with MUL → undef_instr=1, no MD_Start.
- rst_n asserted in BUSY → all outputs reset same cycle, MD_Busy=0.
